// File: rtl/jtag_dmi_tap.sv
// JTAG TAP controller with a RISC-V debug transport module, oversampled on clk_i.
// Turns JTAG DR scans into DMI request/response transactions toward the debug module.
module jtag_dmi_tap #(
    parameter logic [31:0] IdcodeValue = 32'h04F5484D,
    parameter int unsigned DmiAbits    = 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                jtag_tck_i,
    input  logic                jtag_tms_i,
    input  logic                jtag_trst_ni,
    input  logic                jtag_tdi_i,
    output logic                jtag_tdo_o,
    output logic                jtag_tdo_oe_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [DmiAbits-1:0] dmi_req_addr_o,
    output logic [1:0]          dmi_req_op_o,
    output logic [31:0]         dmi_req_data_o,
    input  logic                dmi_rsp_valid_i,
    output logic                dmi_rsp_ready_o,
    input  logic [31:0]         dmi_rsp_data_i,
    input  logic [1:0]          dmi_rsp_resp_i,
    output logic                dmi_rst_no
);

    localparam int unsigned DrW      = DmiAbits + 34;
    localparam logic [4:0]  IrIdcode = 5'h01;
    localparam logic [4:0]  IrDtmcs  = 5'h10;
    localparam logic [4:0]  IrDmi    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI
    } dr_sel_e;

    function automatic logic [31:0] dtmcs_value(input logic [1:0] stat);
        dtmcs_value = {14'b0, 2'b0, 1'b0, 3'd1, stat, 6'(DmiAbits), 4'd1};
    endfunction

    logic                tck_r, tck_q_r, tms_r, tdi_r;
    logic                tck_rise_s, tck_fall_s;
    tap_state_e          state_r, state_nx_s;
    logic [4:0]          ir_r, ir_sh_r;
    logic [DrW-1:0]      dr_r;
    dr_sel_e             dr_sel_s;
    logic                cap_dr_s, sh_dr_s, upd_dr_s, cap_ir_s, sh_ir_s, upd_ir_s;
    logic                dmi_cap_s, dmi_upd_s, dtmcs_upd_s, dmi_op_valid_s;
    logic [1:0]          dmi_status_s;
    logic                tdo_r, tdo_oe_r;
    logic                req_valid_r, busy_r, dmi_rst_n_r, rsp_ready_r;
    logic [DmiAbits-1:0] addr_r;
    logic [1:0]          op_r, sticky_r;
    logic [31:0]         data_r, rsp_data_r;

    // Oversample the JTAG pins; edges come from comparing successive tck samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_r   <= 1'b0;
            tck_q_r <= 1'b0;
            tms_r   <= 1'b0;
            tdi_r   <= 1'b0;
        end else begin
            tck_r   <= jtag_tck_i;
            tck_q_r <= tck_r;
            tms_r   <= jtag_tms_i;
            tdi_r   <= jtag_tdi_i;
        end
    end

    assign tck_rise_s = tck_r & ~tck_q_r;
    assign tck_fall_s = ~tck_r & tck_q_r;

    // TAP state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= TLR;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // IEEE 1149.1 next-state logic; TRST wins over any tck activity
    always_comb begin
        state_nx_s = state_r;
        if (!jtag_trst_ni) begin
            state_nx_s = TLR;
        end else if (tck_rise_s) begin
            case (state_r)
                TLR:     state_nx_s = tms_r ? TLR    : RTI;
                RTI:     state_nx_s = tms_r ? SEL_DR : RTI;
                SEL_DR:  state_nx_s = tms_r ? SEL_IR : CAP_DR;
                CAP_DR:  state_nx_s = tms_r ? EX1_DR : SH_DR;
                SH_DR:   state_nx_s = tms_r ? EX1_DR : SH_DR;
                EX1_DR:  state_nx_s = tms_r ? UPD_DR : PA_DR;
                PA_DR:   state_nx_s = tms_r ? EX2_DR : PA_DR;
                EX2_DR:  state_nx_s = tms_r ? UPD_DR : SH_DR;
                UPD_DR:  state_nx_s = tms_r ? SEL_DR : RTI;
                SEL_IR:  state_nx_s = tms_r ? TLR    : CAP_IR;
                CAP_IR:  state_nx_s = tms_r ? EX1_IR : SH_IR;
                SH_IR:   state_nx_s = tms_r ? EX1_IR : SH_IR;
                EX1_IR:  state_nx_s = tms_r ? UPD_IR : PA_IR;
                PA_IR:   state_nx_s = tms_r ? EX2_IR : PA_IR;
                EX2_IR:  state_nx_s = tms_r ? UPD_IR : SH_IR;
                UPD_IR:  state_nx_s = tms_r ? SEL_DR : RTI;
                default: state_nx_s = TLR;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Per-state actions happen on the rising tck edge that leaves the state
    assign cap_dr_s = tck_rise_s && (state_r == CAP_DR);
    assign sh_dr_s  = tck_rise_s && (state_r == SH_DR);
    assign upd_dr_s = tck_rise_s && (state_r == UPD_DR);
    assign cap_ir_s = tck_rise_s && (state_r == CAP_IR);
    assign sh_ir_s  = tck_rise_s && (state_r == SH_IR);
    assign upd_ir_s = tck_rise_s && (state_r == UPD_IR);

    // Decode the committed instruction into a data register select
    always_comb begin
        dr_sel_s = SEL_BYPASS;
        case (ir_r)
            IrIdcode: dr_sel_s = SEL_IDCODE;
            IrDtmcs:  dr_sel_s = SEL_DTMCS;
            IrDmi:    dr_sel_s = SEL_DMI;
            default:  dr_sel_s = SEL_BYPASS;
        endcase
    end

    assign dmi_cap_s      = cap_dr_s && (dr_sel_s == SEL_DMI);
    assign dmi_upd_s      = upd_dr_s && (dr_sel_s == SEL_DMI);
    assign dtmcs_upd_s    = upd_dr_s && (dr_sel_s == SEL_DTMCS);
    assign dmi_op_valid_s = (dr_r[1:0] == 2'd1) || (dr_r[1:0] == 2'd2);
    assign dmi_status_s   = busy_r ? 2'd3 : sticky_r;

    // Instruction register: capture/shift path plus committed value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_r    <= IrIdcode;
            ir_sh_r <= 5'b00000;
        end else begin
            if (cap_ir_s) begin
                ir_sh_r <= 5'b00001;
            end else if (sh_ir_s) begin
                ir_sh_r <= {tdi_r, ir_sh_r[4:1]};
            end
            if (state_nx_s == TLR) begin
                ir_r <= IrIdcode;
            end else if (upd_ir_s) begin
                ir_r <= ir_sh_r;
            end
        end
    end

    // Shared data shift register; TDI enters at the MSB of the selected length
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dr_r <= {DrW{1'b0}};
        end else if (cap_dr_s) begin
            case (dr_sel_s)
                SEL_IDCODE: dr_r <= {{(DrW-32){1'b0}}, IdcodeValue};
                SEL_DTMCS:  dr_r <= {{(DrW-32){1'b0}}, dtmcs_value(sticky_r)};
                SEL_DMI:    dr_r <= {addr_r, rsp_data_r, dmi_status_s};
                default:    dr_r <= {DrW{1'b0}};
            endcase
        end else if (sh_dr_s) begin
            case (dr_sel_s)
                SEL_IDCODE,
                SEL_DTMCS:  dr_r <= {{(DrW-32){1'b0}}, tdi_r, dr_r[31:1]};
                SEL_DMI:    dr_r <= {tdi_r, dr_r[DrW-1:1]};
                default:    dr_r <= {{(DrW-1){1'b0}}, tdi_r};
            endcase
        end
    end

    // TDO changes on the falling tck edge so the host samples it on the next rise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdo_r    <= 1'b0;
            tdo_oe_r <= 1'b0;
        end else if (tck_fall_s) begin
            if (state_r == SH_IR) begin
                tdo_r    <= ir_sh_r[0];
                tdo_oe_r <= 1'b1;
            end else if (state_r == SH_DR) begin
                tdo_r    <= dr_r[0];
                tdo_oe_r <= 1'b1;
            end else begin
                tdo_r    <= 1'b0;
                tdo_oe_r <= 1'b0;
            end
        end
    end

    // DMI transaction engine; later statements take priority within a cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_r <= 1'b0;
            addr_r      <= {DmiAbits{1'b0}};
            op_r        <= 2'd0;
            data_r      <= 32'd0;
            rsp_data_r  <= 32'd0;
            busy_r      <= 1'b0;
            sticky_r    <= 2'd0;
            dmi_rst_n_r <= 1'b1;
        end else begin
            dmi_rst_n_r <= 1'b1;
            if (req_valid_r && dmi_req_ready_i) begin
                req_valid_r <= 1'b0;
            end
            if (dmi_rsp_valid_i && busy_r) begin
                rsp_data_r <= dmi_rsp_data_i;
                busy_r     <= 1'b0;
                if (dmi_rsp_resp_i != 2'd0) begin
                    sticky_r <= 2'd2;
                end
            end
            if (dmi_cap_s && busy_r) begin
                sticky_r <= 2'd3;
            end
            // A response in this same cycle does not rescue an update seen while busy
            if (dmi_upd_s && dmi_op_valid_s) begin
                if (busy_r) begin
                    sticky_r <= 2'd3;
                end else if (sticky_r == 2'd0) begin
                    addr_r      <= dr_r[DrW-1:34];
                    data_r      <= dr_r[33:2];
                    op_r        <= dr_r[1:0];
                    busy_r      <= 1'b1;
                    req_valid_r <= 1'b1;
                end
            end
            if (dtmcs_upd_s) begin
                if (dr_r[16]) begin
                    sticky_r <= 2'd0;
                end
                if (dr_r[17]) begin
                    sticky_r    <= 2'd0;
                    busy_r      <= 1'b0;
                    req_valid_r <= 1'b0;
                    dmi_rst_n_r <= 1'b0;
                end
            end
        end
    end

    // Response path is always able to accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_ready_r <= 1'b1;
        end else begin
            rsp_ready_r <= 1'b1;
        end
    end

    assign jtag_tdo_o      = tdo_r;
    assign jtag_tdo_oe_o   = tdo_oe_r;
    assign dmi_req_valid_o = req_valid_r;
    assign dmi_req_addr_o  = addr_r;
    assign dmi_req_op_o    = op_r;
    assign dmi_req_data_o  = data_r;
    assign dmi_rsp_ready_o = rsp_ready_r;
    assign dmi_rst_no      = dmi_rst_n_r;

endmodule
